serial_adder: RTL and testbench

//   Bit-serial N-bit adder, one operand bit per clock, LSB first.

---
 rtl/serial_adder_if.sv | 24 ++
 rtl/serial_adder.sv | 143 ++++++++++++++
 tb/tb_serial_adder.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle between the controller and the bit-serial adder.
// The controller drives start and the operands; the adder returns the
// result together with its busy/done status.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  sum, cout, busy, done
  );

  modport slave (
    input  start, a, b,
    output sum, cout, busy, done
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit per clock, LSB first.
// The full-adder slice is two half adders with their carries ORed; a carry
// flop links successive bit cycles. A three-state FSM (IDLE/SHIFT/DONE)
// sequences one add and reports busy/done to the controller.

module half_adder (
  input  logic x,
  input  logic y,
  output logic c,
  output logic s
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [WIDTH-1:0]  sh_a;
  logic [WIDTH-1:0]  sh_b;
  logic [WIDTH-1:0]  sh_sum;
  logic [WIDTH-1:0]  sum_shifted;
  logic [CW-1:0]     count;
  logic              carry;
  logic              last;

  logic              c0;
  logic              s0;
  logic              c1;
  logic              s_bit;
  logic              co;

  logic [WIDTH-1:0]  sum_r;
  logic              cout_r;
  logic              busy_r;
  logic              done_r;

  // First half adder: the two operand bits.
  half_adder u_ha0 (
    .x (sh_a[0]),
    .y (sh_b[0]),
    .c (c0),
    .s (s0)
  );

  // Second half adder: partial sum plus the stored carry.
  half_adder u_ha1 (
    .x (s0),
    .y (carry),
    .c (c1),
    .s (s_bit)
  );

  assign co          = c0 | c1;
  assign last        = (count == LAST);
  assign sum_shifted = {s_bit, sh_sum[WIDTH-1:1]};

  // Next-state logic; start is only looked at in IDLE, so it is never queued.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last)      state_next = DONE;
      DONE:                   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // State register and status flags; done lags DONE by one cycle so it
  // marks the cycle after the result has settled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_next;
      busy_r <= (state_next == SHIFT);
      done_r <= (state == DONE);
    end
  end

  // Operand/sum shift registers, carry flop, bit counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a   <= '0;
      sh_b   <= '0;
      sh_sum <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sh_a   <= bus.a;
            sh_b   <= bus.b;
            sh_sum <= '0;
            carry  <= 1'b0;
            count  <= '0;
          end
        end
        SHIFT: begin
          sh_a   <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b   <= {1'b0, sh_b[WIDTH-1:1]};
          sh_sum <= sum_shifted;
          carry  <= co;
          if (last) begin
            sum_r  <= sum_shifted;
            cout_r <= co;
          end else begin
            count  <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): expected {cout,sum} values
// are queued when an add is launched and popped when done pulses.
`timescale 1ns/1ps
module tb_serial_adder;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [W:0] exp_q[$];

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // Launch one add, then wait (bounded) for done; edges = -1 on timeout.
  task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W:0] got, output int edges);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    exp_q.push_back({1'b0, x} + {1'b0, y});
    tick();
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    edges = -1;
    got   = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.done) begin
        edges = k;
        got   = {bus.cout, bus.sum};
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [W:0] got;
    logic [W:0] exp;
    int edges;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.a = 8'h5A;
    bus.b = 8'h33;
    tick();
    tick();
    checks++;
    if ({bus.sum, bus.cout, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got sum=%h cout=%b busy=%b done=%b, want all 0",
               bus.sum, bus.cout, bus.busy, bus.done);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    tick();
    do_add(8'h00, 8'h00, got, edges);
    exp = pop_exp();
    checks++;
    if (edges !== 9) begin
      errors++;
      $display("FAIL zero_add_latency: got %0d edges, want 9", edges);
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL zero_add_result: got %h, want %h", got, exp);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: got done=%b, want 0", bus.done);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] xa[3] = '{8'hFF, 8'hA5, 8'hFF};
    logic [W-1:0] xb[3] = '{8'h01, 8'h5A, 8'hFF};
    logic [W:0]   want[3] = '{9'h100, 9'h0FF, 9'h1FE};
    logic [W:0] got;
    logic [W:0] exp;
    int edges;
    for (int i = 0; i < 3; i++) begin
      do_add(xa[i], xb[i], got, edges);
      exp = pop_exp();
      checks++;
      if (edges < 0 || got !== exp || got !== want[i]) begin
        errors++;
        $display("FAIL basic_add_%0d: got %h (edges %0d), want %h", i, got, edges, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_ignore_start();
    logic [W:0] exp;
    int busy_cnt;
    int extra_done;
    bit seen;
    bus.start = 1'b1;
    bus.a = 8'h03;
    bus.b = 8'h04;
    exp_q.push_back(9'h007);
    tick();
    bus.start = 1'b0;
    busy_cnt = bus.busy ? 1 : 0;
    tick();
    if (bus.busy) busy_cnt++;
    tick();
    if (bus.busy) busy_cnt++;
    bus.start = 1'b1;
    bus.a = 8'hF0;
    tick();
    bus.start = 1'b0;
    if (bus.busy) busy_cnt++;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (bus.busy) busy_cnt++;
      if (bus.done) seen = 1'b1;
    end
    exp = pop_exp();
    checks++;
    if (!seen || {bus.cout, bus.sum} !== exp) begin
      errors++;
      $display("FAIL ignore_start_result: got %h (done seen %b), want %h",
               {bus.cout, bus.sum}, seen, exp);
    end
    checks++;
    if (busy_cnt !== 8) begin
      errors++;
      $display("FAIL busy_length: got %0d cycles, want 8", busy_cnt);
    end
    extra_done = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.done || bus.busy) extra_done++;
    end
    checks++;
    if (extra_done !== 0) begin
      errors++;
      $display("FAIL ignored_start_queued: got %0d extra active cycles, want 0", extra_done);
    end
  endtask

  task automatic test_mid_reset();
    logic [W:0] got;
    logic [W:0] exp;
    int edges;
    bus.start = 1'b1;
    bus.a = 8'h12;
    bus.b = 8'h34;
    exp_q.push_back(9'h046);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_reset: got %b, want 1", bus.busy);
    end
    rst = 1'b1;
    tick();
    exp_q.delete();
    checks++;
    if ({bus.sum, bus.cout, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got sum=%h cout=%b busy=%b done=%b, want all 0",
               bus.sum, bus.cout, bus.busy, bus.done);
    end
    rst = 1'b0;
    tick();
    do_add(8'hC8, 8'h64, got, edges);
    exp = pop_exp();
    checks++;
    if (edges !== 9 || got !== exp) begin
      errors++;
      $display("FAIL post_reset_add: got %h (edges %0d), want %h at 9 edges", got, edges, exp);
    end
    tick();
  endtask

  task automatic test_continuous();
    logic [W:0]   exp;
    logic [W-1:0] prev_sum;
    logic         prev_busy;
    int last_done;
    int npulse;
    bus.a = 8'h10;
    bus.b = 8'h20;
    bus.start = 1'b1;
    prev_busy = bus.busy;
    prev_sum  = bus.sum;
    last_done = -1;
    npulse = 0;
    for (int t = 0; t < 60; t++) begin
      if (t == 45) bus.start = 1'b0;
      tick();
      if (bus.busy && !prev_busy) exp_q.push_back(9'h030);
      if (bus.busy) begin
        checks++;
        if (bus.sum !== prev_sum) begin
          errors++;
          $display("FAIL sum_hold_t%0d: got %h, want %h", t, bus.sum, prev_sum);
        end
      end
      if (bus.done) begin
        exp = pop_exp();
        checks++;
        if ({bus.cout, bus.sum} !== exp) begin
          errors++;
          $display("FAIL cont_result_t%0d: got %h, want %h", t, {bus.cout, bus.sum}, exp);
        end
        if (last_done >= 0) begin
          checks++;
          if (t - last_done !== 10) begin
            errors++;
            $display("FAIL cont_period: got %0d cycles, want 10", t - last_done);
          end
        end
        last_done = t;
        npulse++;
      end
      prev_busy = bus.busy;
      prev_sum  = bus.sum;
    end
    checks++;
    if (npulse < 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL cont_pulses: got %0d pulses with %0d pending, want >=4 and 0",
               npulse, exp_q.size());
    end
  endtask

  task automatic test_random();
    logic [W:0]   got;
    logic [W:0]   exp;
    logic [W-1:0] x;
    logic [W-1:0] y;
    int edges;
    int bad;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      do_add(x, y, got, edges);
      exp = pop_exp();
      checks++;
      if (edges < 0 || got !== exp) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_%0d: %h+%h got %h (edges %0d), want %h",
                   i, x, y, got, edges, exp);
      end
      if (($urandom % 3) == 0) tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_mid_reset();
    test_continuous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
